// File: rtl/mini_alu_gen_if.sv
// Fetch, LED/LCD and status signals of the mini ALU core.
// master = core side, slave = ROM/LCD/board side.
interface mini_alu_gen_if #(
   parameter int IP_WIDTH = 16
);
   logic [IP_WIDTH-1:0] oIP;
   logic [27:0]         iInstruction;
   logic [7:0]          oLed;
   logic                oLcdWrite;
   logic [7:0]          oLcdData;
   logic                iLcdReady;
   logic                oFault;
   logic                oHalted;

   modport master (
      output oIP, oLed, oLcdWrite, oLcdData, oFault, oHalted,
      input  iInstruction, iLcdReady
   );

   modport slave (
      input  oIP, oLed, oLcdWrite, oLcdData, oFault, oHalted,
      output iInstruction, iLcdReady
   );
endinterface

// File: rtl/mini_alu_gen.sv
// Two-stage (fetch / execute) mini ALU core with a return stack and an LCD byte port.
// The IR is the only pipeline register; execute works straight off the register file.
module mini_alu_gen #(
   parameter int DATA_WIDTH  = 16,
   parameter int REG_COUNT   = 16,
   parameter int IP_WIDTH    = 16,
   parameter int STACK_DEPTH = 4
)(
   input  logic           Clock,
   input  logic           Reset,
   mini_alu_gen_if.master bus
);
   localparam int AW  = (REG_COUNT > 1)   ? $clog2(REG_COUNT)   : 1;
   localparam int SW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int DW  = DATA_WIDTH;

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_STO  = 4'h2;
   localparam logic [3:0] OP_BLE  = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_LED  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_SMUL = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_CALL = 4'h9;
   localparam logic [3:0] OP_RET  = 4'hA;
   localparam logic [3:0] OP_LCD  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [27:0] NOP_WORD = 28'h0;

   typedef enum logic [1:0] {S_RUN, S_LCD_WAIT, S_HALTED} state_t;

   state_t                r_state;
   logic [27:0]           r_ir;
   logic [IP_WIDTH-1:0]   r_ip;
   logic [DW-1:0]         r_rf  [REG_COUNT];
   logic [IP_WIDTH-1:0]   r_stk [STACK_DEPTH];
   logic [SPW-1:0]        r_sp;
   logic [7:0]            r_led;
   logic                  r_fault;
   logic                  r_halted;

   logic [3:0]            w_op;
   logic [AW-1:0]         w_dst, w_dst_hi, w_s1, w_s0;
   logic [DW-1:0]         w_a, w_b, w_sto, w_shl;
   logic signed [2*DW-1:0] w_as, w_bs, w_prod;
   logic [IP_WIDTH-1:0]   w_dst_ip, w_target;
   logic [SW-1:0]         w_push_idx, w_top_idx;
   logic                  w_taken, w_fault, w_halt, w_lcd, w_stall;

   assign w_op     = r_ir[27:24];
   assign w_dst    = r_ir[16 +: AW];
   assign w_s1     = r_ir[8  +: AW];
   assign w_s0     = r_ir[0  +: AW];
   assign w_dst_hi = (w_dst == AW'(REG_COUNT - 1)) ? '0 : w_dst + 1'b1;
   assign w_a      = r_rf[w_s1];
   assign w_b      = r_rf[w_s0];

   assign w_sto    = DW'(r_ir[15:0]);
   assign w_shl    = (32'(w_b) >= DATA_WIDTH) ? '0 : (w_a << w_b);
   // Sign-extend to full product width so the low 2*DW bits are the exact signed product.
   assign w_as     = {{DW{w_a[DW-1]}}, w_a};
   assign w_bs     = {{DW{w_b[DW-1]}}, w_b};
   assign w_prod   = w_as * w_bs;

   assign w_dst_ip   = IP_WIDTH'(r_ir[23:16]);
   assign w_push_idx = SW'(r_sp);
   assign w_top_idx  = SW'(r_sp - 1'b1);

   always_comb begin
      w_taken  = 1'b0;
      w_fault  = 1'b0;
      w_halt   = 1'b0;
      w_target = w_dst_ip;
      if (r_state != S_HALTED) begin
         case (w_op)
            OP_BLE:  w_taken = ($signed(w_a) <= $signed(w_b));
            OP_JMP:  w_taken = 1'b1;
            OP_CALL: begin
               if (r_sp == SPW'(STACK_DEPTH)) w_fault = 1'b1;
               else                           w_taken = 1'b1;
            end
            OP_RET: begin
               w_target = r_stk[w_top_idx];
               if (r_sp == '0) w_fault = 1'b1;
               else            w_taken = 1'b1;
            end
            OP_HALT: w_halt = 1'b1;
            default: ;
         endcase
      end
   end

   // The LCD byte is presented for as long as the LCD instruction sits in the IR.
   assign w_lcd   = (w_op == OP_LCD) && (r_state != S_HALTED);
   assign w_stall = w_lcd && !bus.iLcdReady;

   assign bus.oIP       = r_ip;
   assign bus.oLed      = r_led;
   assign bus.oLcdWrite = w_lcd;
   assign bus.oLcdData  = w_lcd ? w_b[7:0] : 8'h00;
   assign bus.oFault    = r_fault;
   assign bus.oHalted   = r_halted;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state  <= S_RUN;
         r_ir     <= NOP_WORD;
         r_ip     <= '0;
         r_sp     <= '0;
         r_led    <= '0;
         r_fault  <= 1'b0;
         r_halted <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++)   r_rf[i]  <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) r_stk[i] <= '0;
      end else begin
         case (r_state)
            S_RUN, S_LCD_WAIT: begin
               if (w_fault || w_halt) begin
                  // Freeze everything where it stands; only reset leaves HALTED.
                  r_state  <= S_HALTED;
                  r_halted <= 1'b1;
                  r_fault  <= r_fault | w_fault;
               end else if (w_stall) begin
                  r_state <= S_LCD_WAIT;
               end else begin
                  r_state <= S_RUN;
                  if (w_taken) begin
                     r_ip <= w_target;
                     r_ir <= NOP_WORD;
                  end else begin
                     r_ip <= r_ip + 1'b1;
                     r_ir <= bus.iInstruction;
                  end
                  case (w_op)
                     OP_ADD:  r_rf[w_dst] <= w_a + w_b;
                     OP_SUB:  r_rf[w_dst] <= w_a - w_b;
                     OP_STO:  r_rf[w_dst] <= w_sto;
                     OP_SHL:  r_rf[w_dst] <= w_shl;
                     OP_SMUL: begin
                        r_rf[w_dst]    <= w_prod[DW-1:0];
                        r_rf[w_dst_hi] <= w_prod[2*DW-1:DW];
                     end
                     OP_LED:  r_led <= w_a[7:0];
                     OP_CALL: begin
                        // r_ip already points one past the CALL.
                        r_stk[w_push_idx] <= r_ip;
                        r_sp              <= r_sp + 1'b1;
                     end
                     OP_RET:  r_sp <= r_sp - 1'b1;
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end
endmodule
